// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - shared FSM state and stall-cause encodings for stall_ctrl
package stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    // Stall cause codes: 0 = none, k = hazard bit k-1, all-ones = multi-cycle wait only.
    localparam int unsigned SRC_NONE = 0;

    function automatic int unsigned src_hazard_code(input int unsigned idx);
        return idx + 32'd1;
    endfunction

    function automatic int unsigned src_mc_code(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall/flush controller with multi-cycle wait,
// stall-cause tracking, stall performance counter and stall watchdog
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int MC_W      = 6,
    parameter int FLUSH_LEN = 2,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_SRC-1:0]             i_stall_req,
    input  logic                           i_mc_start,
    input  logic [MC_W-1:0]                i_mc_cycles,
    input  logic                           i_flush_req,
    output logic                           o_stall,
    output logic                           o_stall_registered,
    output logic                           o_capture,
    output logic                           o_flush,
    output logic [$clog2(NUM_SRC+1)-1:0]   o_stall_src,
    output logic [CNT_W-1:0]               o_stall_cycles,
    output logic                           o_timeout
);

    localparam int SRC_W = $clog2(NUM_SRC + 1);
    localparam int FL_W  = $clog2(FLUSH_LEN + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [SRC_W-1:0] SRC_NONE_C = SRC_W'(SRC_NONE);
    localparam logic [SRC_W-1:0] SRC_MC_C   = SRC_W'(src_mc_code(SRC_W));

    state_e             state_q, state_d;
    logic [MC_W-1:0]    mc_cnt_q, mc_cnt_d;
    logic [FL_W-1:0]    fl_cnt_q, fl_cnt_d;
    logic               stall_reg_q, stall_reg_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic               timeout_q, timeout_d;
    logic [WD_W-1:0]    wd_count;

    logic               any_hazard;
    logic               in_mc;
    logic               in_fl;
    logic               stall;
    logic               flush;

    assign any_hazard = |i_stall_req;
    assign in_mc      = (state_q == ST_MC_WAIT);
    assign in_fl      = (state_q == ST_FLUSH);

    // Next state and combinational outputs. Reset gates the FSM-derived terms so
    // a stale MC_WAIT/FLUSH state cannot leak out during the reset cycle.
    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        fl_cnt_d = fl_cnt_q;
        stall    = 1'b0;
        flush    = 1'b0;

        if (i_reset) begin
            stall = any_hazard;
        end else begin
            stall = (any_hazard | in_mc) & ~in_fl;
            flush = in_fl;
        end

        if (i_flush_req) begin
            state_d  = ST_FLUSH;
            fl_cnt_d = FL_W'(FLUSH_LEN);
            mc_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_mc_start && (i_mc_cycles != '0)) begin
                        state_d  = ST_MC_WAIT;
                        mc_cnt_d = i_mc_cycles;
                    end
                end
                ST_MC_WAIT: begin
                    if (mc_cnt_q <= MC_W'(1)) begin
                        state_d  = ST_RUN;
                        mc_cnt_d = '0;
                    end else begin
                        mc_cnt_d = mc_cnt_q - MC_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (fl_cnt_q <= FL_W'(1)) begin
                        state_d  = ST_RUN;
                        fl_cnt_d = '0;
                    end else begin
                        fl_cnt_d = fl_cnt_q - FL_W'(1);
                    end
                end
                default: begin
                    state_d  = ST_RUN;
                    mc_cnt_d = '0;
                    fl_cnt_d = '0;
                end
            endcase
        end
    end

    // Lowest-numbered hazard wins; a bare multi-cycle wait reports all-ones.
    always_comb begin
        src_d = SRC_NONE_C;
        if (in_mc) begin
            src_d = SRC_MC_C;
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_stall_req[i]) begin
                src_d = SRC_W'(src_hazard_code(i));
            end
        end
    end

    assign stall_reg_d = stall & ~in_fl & ~i_flush_req;
    assign timeout_d   = timeout_q | (stall & (wd_count == WD_W'(TIMEOUT - 1)));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_RUN;
            mc_cnt_q    <= '0;
            fl_cnt_q    <= '0;
            stall_reg_q <= 1'b0;
            src_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            fl_cnt_q    <= fl_cnt_d;
            stall_reg_q <= stall_reg_d;
            src_q       <= src_d;
            timeout_q   <= timeout_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_perf_cnt (
        .clk_i   (i_clk),
        .reset_i (i_reset),
        .inc_i   (stall),
        .clear_i (1'b0),
        .count_o (o_stall_cycles)
    );

    // Watchdog measures the current unbroken stall run only.
    sat_counter #(
        .WIDTH (WD_W)
    ) u_watchdog (
        .clk_i   (i_clk),
        .reset_i (i_reset),
        .inc_i   (stall),
        .clear_i (~stall),
        .count_o (wd_count)
    );

    assign o_stall            = stall;
    assign o_flush            = flush;
    assign o_stall_registered = stall_reg_q;
    assign o_capture          = stall & ~stall_reg_q;
    assign o_stall_src        = src_q;
    assign o_timeout          = timeout_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - self-checking bench for stall_ctrl with directed scenarios and a reference model
module tb_stall_ctrl;

    localparam int NUM_SRC   = 4;
    localparam int MC_W      = 6;
    localparam int FLUSH_LEN = 2;
    localparam int CNT_W     = 4;
    localparam int TIMEOUT   = 24;
    localparam int SRC_W     = $clog2(NUM_SRC + 1);
    localparam int SRC_ALL1  = (1 << SRC_W) - 1;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_SRC-1:0] stall_req;
    logic               mc_start;
    logic [MC_W-1:0]    mc_cycles;
    logic               flush_req;
    logic               o_stall, o_stall_registered, o_capture, o_flush, o_timeout;
    logic [SRC_W-1:0]   o_stall_src;
    logic [CNT_W-1:0]   o_stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stall_ctrl #(
        .NUM_SRC   (NUM_SRC),
        .MC_W      (MC_W),
        .FLUSH_LEN (FLUSH_LEN),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_stall_req        (stall_req),
        .i_mc_start         (mc_start),
        .i_mc_cycles        (mc_cycles),
        .i_flush_req        (flush_req),
        .o_stall            (o_stall),
        .o_stall_registered (o_stall_registered),
        .o_capture          (o_capture),
        .o_flush            (o_flush),
        .o_stall_src        (o_stall_src),
        .o_stall_cycles     (o_stall_cycles),
        .o_timeout          (o_timeout)
    );

    // Reference model: remaining multi-cycle and flush cycles, length of current stall run.
    int m_mc_left = 0;
    int m_fl_left = 0;
    int m_src     = 0;
    int m_cycles  = 0;
    int m_run     = 0;
    bit m_stall_reg = 1'b0;
    bit m_to        = 1'b0;

    function automatic bit model_stall();
        if (reset) return (stall_req != 0);
        return ((stall_req != 0) || (m_mc_left > 0)) && (m_fl_left == 0);
    endfunction

    function automatic bit model_flush();
        return !reset && (m_fl_left > 0);
    endfunction

    function automatic int model_cause();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (stall_req[i]) return i + 1;
        end
        return (m_mc_left > 0) ? SRC_ALL1 : 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mc_left   <= 0;
            m_fl_left   <= 0;
            m_src       <= 0;
            m_cycles    <= 0;
            m_run       <= 0;
            m_stall_reg <= 1'b0;
            m_to        <= 1'b0;
        end else begin
            m_stall_reg <= model_stall() && !flush_req;
            m_src       <= model_cause();
            if (model_stall()) begin
                m_cycles <= (m_cycles >= CNT_MAX) ? CNT_MAX : m_cycles + 1;
                m_run    <= m_run + 1;
                if (m_run + 1 >= TIMEOUT) m_to <= 1'b1;
            end else begin
                m_run <= 0;
            end
            if (flush_req) begin
                m_fl_left <= FLUSH_LEN;
                m_mc_left <= 0;
            end else if (m_fl_left > 0) begin
                m_fl_left <= m_fl_left - 1;
            end else if (m_mc_left > 0) begin
                m_mc_left <= m_mc_left - 1;
            end else if (mc_start && mc_cycles != 0) begin
                m_mc_left <= int'(mc_cycles);
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [NUM_SRC-1:0] r, input logic s, input logic [MC_W-1:0] m, input logic f);
        stall_req = r;
        mc_start  = s;
        mc_cycles = m;
        flush_req = f;
    endtask

    task automatic do_reset();
        apply('0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        next_cyc();
        next_cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply('0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        next_cyc();
        @(negedge clk);
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", o_stall); end
        n_checks++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", o_flush); end
        n_checks++; if (o_stall_registered !== 1'b0) begin n_fail++; $display("FAIL reset_stall_reg got %b exp 0", o_stall_registered); end
        n_checks++; if (o_stall_src !== '0) begin n_fail++; $display("FAIL reset_src got %0d exp 0", o_stall_src); end
        n_checks++; if (o_stall_cycles !== '0) begin n_fail++; $display("FAIL reset_cycles got %0d exp 0", o_stall_cycles); end
        n_checks++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", o_timeout); end
        next_cyc();
        stall_req = 4'b0010;
        @(negedge clk);
        n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL reset_hazard_stall got %b exp 1", o_stall); end
        n_checks++; if (o_capture !== 1'b1) begin n_fail++; $display("FAIL reset_hazard_capture got %b exp 1", o_capture); end
        next_cyc();
        @(negedge clk);
        n_checks++; if (o_stall_src !== '0) begin n_fail++; $display("FAIL reset_hazard_src got %0d exp 0", o_stall_src); end
        n_checks++; if (o_stall_registered !== 1'b0) begin n_fail++; $display("FAIL reset_hazard_reg got %b exp 0", o_stall_registered); end
        reset = 1'b0;
        stall_req = '0;
        next_cyc();
    endtask

    task automatic test_hazard();
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            stall_req = (c < 3) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            n_checks++; if (o_stall !== (c < 3)) begin n_fail++; $display("FAIL hazard_stall c=%0d got %b", c, o_stall); end
            n_checks++; if (o_capture !== (c == 0)) begin n_fail++; $display("FAIL hazard_capture c=%0d got %b", c, o_capture); end
            n_checks++; if (o_stall_registered !== (c >= 1 && c <= 3)) begin n_fail++; $display("FAIL hazard_reg c=%0d got %b", c, o_stall_registered); end
            n_checks++; if (o_stall_src !== SRC_W'((c >= 1 && c <= 3) ? 3 : 0)) begin n_fail++; $display("FAIL hazard_src c=%0d got %0d", c, o_stall_src); end
            next_cyc();
        end
        @(negedge clk);
        n_checks++; if (o_stall_cycles !== CNT_W'(3)) begin n_fail++; $display("FAIL hazard_cycles got %0d exp 3", o_stall_cycles); end
        next_cyc();
    endtask

    task automatic test_multicycle();
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            apply('0, (c == 0) || (c == 3), (c == 3) ? MC_W'(9) : MC_W'(5), 1'b0);
            @(negedge clk);
            n_checks++; if (o_stall !== (c >= 1 && c <= 5)) begin n_fail++; $display("FAIL mc_stall c=%0d got %b", c, o_stall); end
            n_checks++; if (o_capture !== (c == 1)) begin n_fail++; $display("FAIL mc_capture c=%0d got %b", c, o_capture); end
            if (c == 2) begin
                n_checks++; if (o_stall_src !== SRC_W'(SRC_ALL1)) begin n_fail++; $display("FAIL mc_src got %0d exp %0d", o_stall_src, SRC_ALL1); end
            end
            if (c == 6) begin
                n_checks++; if (o_stall_cycles !== CNT_W'(5)) begin n_fail++; $display("FAIL mc_cycles got %0d exp 5", o_stall_cycles); end
            end
            next_cyc();
        end
        apply('0, 1'b1, '0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (o_stall !== 1'b0 || o_flush !== 1'b0) begin n_fail++; $display("FAIL mc_zero c=%0d stall %b flush %b exp 0 0", c, o_stall, o_flush); end
            next_cyc();
            mc_start = 1'b0;
        end
    endtask

    task automatic test_flush_in_mc();
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            apply((c == 3) ? 4'b0001 : 4'b0000, c == 0, MC_W'(5), c == 2);
            @(negedge clk);
            n_checks++; if (o_stall !== (c >= 1 && c <= 2)) begin n_fail++; $display("FAIL flush_stall c=%0d got %b", c, o_stall); end
            n_checks++; if (o_flush !== (c >= 3 && c <= 4)) begin n_fail++; $display("FAIL flush_flush c=%0d got %b", c, o_flush); end
            if (c >= 3) begin
                n_checks++; if (o_stall_registered !== 1'b0) begin n_fail++; $display("FAIL flush_reg c=%0d got %b exp 0", c, o_stall_registered); end
            end
            next_cyc();
        end
    endtask

    task automatic test_combined();
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            apply((c >= 2 && c <= 7) ? 4'b1010 : 4'b0000, c == 0, MC_W'(6), 1'b0);
            @(negedge clk);
            n_checks++; if (o_stall !== (c >= 1 && c <= 7)) begin n_fail++; $display("FAIL comb_stall c=%0d got %b", c, o_stall); end
            n_checks++; if (o_capture !== (c == 1)) begin n_fail++; $display("FAIL comb_capture c=%0d got %b", c, o_capture); end
            n_checks++; if (o_stall_src !== SRC_W'((c == 2) ? SRC_ALL1 : (c >= 3) ? 2 : 0)) begin n_fail++; $display("FAIL comb_src c=%0d got %0d", c, o_stall_src); end
            next_cyc();
        end
        @(negedge clk);
        n_checks++; if (o_stall_cycles !== CNT_W'(7)) begin n_fail++; $display("FAIL comb_cycles got %0d exp 7", o_stall_cycles); end
        next_cyc();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c <= TIMEOUT + 1; c++) begin
            stall_req = (c < TIMEOUT) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            n_checks++; if (o_timeout !== (c >= TIMEOUT)) begin n_fail++; $display("FAIL timeout c=%0d got %b", c, o_timeout); end
            next_cyc();
        end
        do_reset();
        @(negedge clk);
        n_checks++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_cleared got %b exp 0", o_timeout); end
        for (int c = 0; c < 2 * TIMEOUT; c++) begin
            stall_req = ((c % TIMEOUT) == TIMEOUT - 1) ? 4'b0000 : 4'b1000;
            next_cyc();
        end
        stall_req = '0;
        @(negedge clk);
        n_checks++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_near_miss got %b exp 0", o_timeout); end
        next_cyc();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int c = 0; c <= 21; c++) begin
            stall_req = (c < 20) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            n_checks++; if (o_stall_cycles !== CNT_W'((c > CNT_MAX) ? CNT_MAX : c)) begin n_fail++; $display("FAIL sat_cycles c=%0d got %0d", c, o_stall_cycles); end
            next_cyc();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply('0, 1'b1, MC_W'(10), 1'b0);
        next_cyc();
        mc_start = 1'b0;
        next_cyc();
        next_cyc();
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_mc_stall got %b exp 0", o_stall); end
        next_cyc();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (o_stall !== 1'b0 || o_flush !== 1'b0) begin n_fail++; $display("FAIL rstmid_mc_after c=%0d stall %b flush %b", c, o_stall, o_flush); end
            next_cyc();
        end
        flush_req = 1'b1;
        next_cyc();
        flush_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL rstmid_fl_flush got %b exp 0", o_flush); end
        next_cyc();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (o_stall !== 1'b0 || o_flush !== 1'b0) begin n_fail++; $display("FAIL rstmid_fl_after c=%0d stall %b flush %b", c, o_stall, o_flush); end
            next_cyc();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            stall_req = ($urandom_range(0, 3) == 0) ? NUM_SRC'($urandom) : '0;
            mc_start  = ($urandom_range(0, 5) == 0);
            mc_cycles = MC_W'($urandom_range(0, 7));
            flush_req = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            n_checks++; if (o_stall !== model_stall()) begin n_fail++; $display("FAIL rnd_stall c=%0d got %b exp %b", c, o_stall, model_stall()); end
            n_checks++; if (o_flush !== model_flush()) begin n_fail++; $display("FAIL rnd_flush c=%0d got %b exp %b", c, o_flush, model_flush()); end
            n_checks++; if (o_stall_registered !== m_stall_reg) begin n_fail++; $display("FAIL rnd_reg c=%0d got %b exp %b", c, o_stall_registered, m_stall_reg); end
            n_checks++; if (o_capture !== (model_stall() && !m_stall_reg)) begin n_fail++; $display("FAIL rnd_capture c=%0d got %b", c, o_capture); end
            n_checks++; if (o_stall_src !== SRC_W'(m_src)) begin n_fail++; $display("FAIL rnd_src c=%0d got %0d exp %0d", c, o_stall_src, m_src); end
            n_checks++; if (o_stall_cycles !== CNT_W'(m_cycles)) begin n_fail++; $display("FAIL rnd_cycles c=%0d got %0d exp %0d", c, o_stall_cycles, m_cycles); end
            n_checks++; if (o_timeout !== m_to) begin n_fail++; $display("FAIL rnd_timeout c=%0d got %b exp %b", c, o_timeout, m_to); end
            next_cyc();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        apply('0, 1'b0, '0, 1'b0);
        test_reset();
        test_hazard();
        test_multicycle();
        test_flush_in_mc();
        test_combined();
        test_timeout();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
